// File: rtl/cpu_control_unit_if.sv
// Instruction-memory and data-memory bus of the accumulator CPU.
// The master side is the control unit; the slave side is the memory system.
interface cpu_control_unit_if;
  logic [11:0] addr;
  logic [15:0] ins;
  logic [11:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_we;
  logic [15:0] dm_rdata;

  modport master (
    output addr,
    output dm_addr,
    output dm_wdata,
    output dm_we,
    input  ins,
    input  dm_rdata
  );

  modport slave (
    input  addr,
    input  dm_addr,
    input  dm_wdata,
    input  dm_we,
    output ins,
    output dm_rdata
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/execute sequencer for the 16-bit accumulator machine.
// Holds PC, IR, ACC and carry; drives instruction and data memory ports.
module cpu_control_unit (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  cpu_control_unit_if.master         bus,
  output logic [15:0]                acc,
  output logic                       carry,
  output logic                       halted,
  output logic [1:0]                 state
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    MEM   = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t      st;
  logic [11:0] pc;
  logic [15:0] ir;
  logic [15:0] acc_q;
  logic        carry_q;
  logic        halted_q;

  logic [3:0]  op;
  logic [11:0] x;
  logic [11:0] pc_inc;
  logic [11:0] pc_rel;
  logic [16:0] sum;

  logic op_cla;
  logic op_com;
  logic op_shr;
  logic op_csl;
  logic op_stp;
  logic op_add;
  logic op_sta;
  logic op_lda;
  logic op_jmp;
  logic op_ban;

  assign op     = ir[15:12];
  assign x      = ir[11:0];
  assign pc_inc = pc + 12'd1;
  assign pc_rel = pc + x;
  assign sum    = {1'b0, acc_q} + {1'b0, bus.dm_rdata};

  assign op_cla = (op == 4'h0);
  assign op_com = (op == 4'h1);
  assign op_shr = (op == 4'h2);
  assign op_csl = (op == 4'h3);
  assign op_stp = (op == 4'h4);
  assign op_add = (op == 4'h5);
  assign op_sta = (op == 4'h6);
  assign op_lda = (op == 4'h7);
  assign op_jmp = (op == 4'h8);
  assign op_ban = (op == 4'h9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= FETCH;
      pc       <= '0;
      ir       <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (st)
        FETCH: begin
          if (run) begin
            ir <= bus.ins;
            st <= EXEC;
          end
        end
        EXEC: begin
          st <= FETCH;
          pc <= pc_inc;
          unique case (1'b1)
            op_cla: acc_q <= '0;
            op_com: acc_q <= ~acc_q;
            op_shr: acc_q <= {acc_q[15], acc_q[15:1]};
            op_csl: acc_q <= {acc_q[14:0], acc_q[15]};
            op_stp: begin
              st       <= HALT;
              pc       <= pc;
              halted_q <= 1'b1;
            end
            op_add, op_lda: begin
              st <= MEM;
              pc <= pc;
            end
            op_jmp: pc <= x;
            op_ban: begin
              if (acc_q[15]) pc <= pc_rel;
            end
            default: ;
          endcase
        end
        MEM: begin
          // only LDA and ADD ever reach this state
          if (op_lda) begin
            acc_q <= bus.dm_rdata;
          end else begin
            {carry_q, acc_q} <= sum;
          end
          pc <= pc_inc;
          st <= FETCH;
        end
        HALT: ;
        default: st <= FETCH;
      endcase
    end
  end

  assign bus.addr     = pc;
  assign bus.dm_addr  = (st == EXEC || st == MEM) ? x : 12'h000;
  assign bus.dm_wdata = acc_q;
  assign bus.dm_we    = (st == EXEC) && op_sta;

  assign acc    = acc_q;
  assign carry  = carry_q;
  assign halted = halted_q;
  assign state  = st;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: vector table, corner
// sequences and a random program checked by an instruction-level model.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] acc;
  logic        carry;
  logic        halted;
  logic [1:0]  state;

  cpu_control_unit_if bus();

  cpu_control_unit dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .bus(bus),
    .acc(acc),
    .carry(carry),
    .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [4096];
  logic [15:0] dmem [4096];
  logic [15:0] mm   [4096];
  bit          used [4096];

  assign bus.ins = imem[bus.addr];

  always @(posedge clk) begin
    if (bus.dm_we) dmem[bus.dm_addr] <= bus.dm_wdata;
    bus.dm_rdata <= dmem[bus.dm_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int          cyc;
  int          we_cnt;
  logic [11:0] we_addr;
  logic [15:0] we_data;

  task automatic exec1();
    cyc = 0;
    we_cnt = 0;
    we_addr = '0;
    we_data = '0;
    run = 1'b1;
    do begin
      if (bus.dm_we === 1'b1) begin
        we_cnt++;
        we_addr = bus.dm_addr;
        we_data = bus.dm_wdata;
      end
      @(posedge clk);
      #1;
      cyc++;
    end while (state != 2'b00 && state != 2'b11 && cyc < 8);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] acc;
    logic        c;
    logic [11:0] pc;
    int          cyc;
  } vec_t;

  vec_t tv [23];

  int          pc_cur;
  int          m_pc, m_acc, m_c, npc, ecyc, s, xi, opi;
  bit          ewe;
  logic [3:0]  opr;
  logic [15:0] w;
  logic [15:0] v;
  logic [11:0] pc_hold;
  bit          bad_we;
  bit          moved;

  initial begin
    tv[0]  = '{16'h7000, 16'h8001, 1'b0, 12'h001, 3};
    tv[1]  = '{16'h1000, 16'h7FFE, 1'b0, 12'h002, 2};
    tv[2]  = '{16'h2000, 16'h3FFF, 1'b0, 12'h003, 2};
    tv[3]  = '{16'h3000, 16'h7FFE, 1'b0, 12'h004, 2};
    tv[4]  = '{16'h1000, 16'h8001, 1'b0, 12'h005, 2};
    tv[5]  = '{16'h9002, 16'h8001, 1'b0, 12'h007, 2};
    tv[6]  = '{16'h8009, 16'h8001, 1'b0, 12'h009, 2};
    tv[7]  = '{16'h9002, 16'h8001, 1'b0, 12'h00B, 2};
    tv[8]  = '{16'h0000, 16'h0000, 1'b0, 12'h00C, 2};
    tv[9]  = '{16'h1000, 16'hFFFF, 1'b0, 12'h00D, 2};
    tv[10] = '{16'h5001, 16'h0000, 1'b1, 12'h00E, 3};
    tv[11] = '{16'h0000, 16'h0000, 1'b1, 12'h00F, 2};
    tv[12] = '{16'h9002, 16'h0000, 1'b1, 12'h010, 2};
    tv[13] = '{16'h7003, 16'h1234, 1'b1, 12'h011, 3};
    tv[14] = '{16'h6002, 16'h1234, 1'b1, 12'h012, 2};
    tv[15] = '{16'hA000, 16'h1234, 1'b1, 12'h013, 2};
    tv[16] = '{16'hF123, 16'h1234, 1'b1, 12'h014, 2};
    tv[17] = '{16'h8FFF, 16'h1234, 1'b1, 12'hFFF, 2};
    tv[18] = '{16'hB000, 16'h1234, 1'b1, 12'h000, 2};
    tv[19] = '{16'h3000, 16'h2468, 1'b1, 12'h001, 2};
    tv[20] = '{16'h9FFF, 16'h2468, 1'b1, 12'h002, 2};
    tv[21] = '{16'h1000, 16'hDB97, 1'b1, 12'h003, 2};
    tv[22] = '{16'h9FFF, 16'hDB97, 1'b1, 12'h002, 2};

    for (int i = 0; i < 4096; i++) begin
      imem[i] = 16'hA000;
      dmem[i] <= 16'h0000;
    end
    #1;
    dmem[0] <= 16'h8001;
    dmem[1] <= 16'h0001;
    dmem[3] <= 16'h1234;

    do_reset();
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_dm_we", 32'(bus.dm_we), 0);
    chk("rst_dm_addr", 32'(bus.dm_addr), 0);

    pc_cur = 0;
    for (int i = 0; i < 23; i++) begin
      imem[pc_cur] = tv[i].ins;
      exec1();
      chk($sformatf("tv%0d_acc", i), 32'(acc), 32'(tv[i].acc));
      chk($sformatf("tv%0d_carry", i), 32'(carry), 32'(tv[i].c));
      chk($sformatf("tv%0d_pc", i), 32'(bus.addr), 32'(tv[i].pc));
      chk($sformatf("tv%0d_cycles", i), cyc, tv[i].cyc);
      if (tv[i].ins[15:12] == 4'h6) begin
        chk($sformatf("tv%0d_we_cnt", i), we_cnt, 1);
        chk($sformatf("tv%0d_we_addr", i), 32'(we_addr), 32'(tv[i].ins[11:0]));
        chk($sformatf("tv%0d_we_data", i), 32'(we_data), 32'(tv[i].acc));
        chk($sformatf("tv%0d_mem", i), 32'(dmem[tv[i].ins[11:0]]), 32'(tv[i].acc));
      end else begin
        chk($sformatf("tv%0d_we_cnt", i), we_cnt, 0);
      end
      pc_cur = int'(tv[i].pc);
    end

    // asynchronous reset while an STA is in EXEC
    imem[2] = 16'h6005;
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("sta_state", 32'(state), 1);
    chk("sta_we", 32'(bus.dm_we), 1);
    chk("sta_dm_addr", 32'(bus.dm_addr), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_addr", 32'(bus.addr), 0);
    chk("arst_acc", 32'(acc), 0);
    chk("arst_carry", 32'(carry), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_dm_we", 32'(bus.dm_we), 0);
    chk("arst_dm_addr", 32'(bus.dm_addr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("arst_nowrite", 32'(dmem[5]), 0);
    chk("arst_release_addr", 32'(bus.addr), 0);

    // stall with run low
    run = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_state", 32'(state), 0);
    chk("stall_addr", 32'(bus.addr), 0);
    chk("stall_acc", 32'(acc), 0);

    // random program against an instruction-level model
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      v = 16'($urandom);
      dmem[i] <= v;
      mm[i] = v;
      used[i] = 1'b0;
    end
    #1;
    m_pc = 0;
    m_acc = 0;
    m_c = 0;
    for (int k = 0; k < 300; k++) begin
      if (!used[m_pc]) begin
        opr = 4'($urandom_range(0, 15));
        if (opr == 4'h4) opr = 4'hA;
        imem[m_pc] = {opr, 12'($urandom)};
        used[m_pc] = 1'b1;
      end
      w = imem[m_pc];
      opi = int'(w[15:12]);
      xi = int'(w[11:0]);
      npc = (m_pc + 1) % 4096;
      ecyc = 2;
      ewe = 1'b0;
      case (opi)
        0: m_acc = 0;
        1: m_acc = 65535 - m_acc;
        2: m_acc = (m_acc >= 32768) ? (m_acc / 2 + 32768) : (m_acc / 2);
        3: m_acc = (m_acc * 2) % 65536 + m_acc / 32768;
        5: begin
          s = m_acc + int'(mm[xi]);
          m_acc = s % 65536;
          m_c = s / 65536;
          ecyc = 3;
        end
        6: begin
          mm[xi] = 16'(m_acc);
          ewe = 1'b1;
        end
        7: begin
          m_acc = int'(mm[xi]);
          ecyc = 3;
        end
        8: npc = xi;
        9: if (m_acc >= 32768) npc = (m_pc + xi) % 4096;
        default: ;
      endcase
      exec1();
      chk($sformatf("rnd%0d_acc", k), 32'(acc), m_acc);
      chk($sformatf("rnd%0d_carry", k), 32'(carry), m_c);
      chk($sformatf("rnd%0d_pc", k), 32'(bus.addr), npc);
      chk($sformatf("rnd%0d_cycles", k), cyc, ecyc);
      chk($sformatf("rnd%0d_we_cnt", k), we_cnt, ewe ? 1 : 0);
      if (ewe) begin
        chk($sformatf("rnd%0d_mem", k), 32'(dmem[xi]), m_acc);
      end
      m_pc = npc;
    end

    // STP and the terminal HALT state
    imem[m_pc] = 16'h4000;
    exec1();
    chk("stp_cycles", cyc, 2);
    chk("stp_state", 32'(state), 3);
    chk("stp_halted", 32'(halted), 1);
    chk("stp_pc", 32'(bus.addr), m_pc);
    pc_hold = bus.addr;
    bad_we = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      @(posedge clk);
      #1;
      if (bus.dm_we !== 1'b0) bad_we = 1'b1;
      if (bus.addr !== pc_hold || state !== 2'b11) moved = 1'b1;
    end
    chk("halt_no_we", 32'(bad_we), 0);
    chk("halt_frozen", 32'(moved), 0);
    chk("halt_acc", 32'(acc), m_acc);
    chk("halt_halted", 32'(halted), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
